// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator machine.
// Owns PC, IR, MAR, ACC and latched flags; talks to an external ALU and a sync 256x8 memory.
module control_unit #(
    parameter logic [7:0] RST_PC = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       run_i,
    output logic [7:0] mem_addr_o,
    output logic       mem_rd_o,
    output logic       mem_wr_o,
    input  logic [7:0] mem_data_i,
    output logic [7:0] mem_data_o,
    output logic [7:0] alu_x_o,
    output logic [7:0] alu_y_o,
    output logic [2:0] alu_op_o,
    input  logic [7:0] alu_r_i,
    input  logic [1:0] alu_flags_i,
    output logic [7:0] pc_o,
    output logic [7:0] acc_o,
    output logic [1:0] flags_o,
    output logic       halted_o,
    output logic       illegal_o
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        FETCHA,
        LOADA,
        STORE,
        READ,
        EXEC,
        HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_LDA = 3'b010;

    state_t     state_reg, state_next;
    logic [7:0] pc_reg, pc_next;
    // Only the opcode nibble of the instruction byte is ever decoded, so only it is kept.
    logic [3:0] ir_reg, ir_next;
    logic [7:0] mar_reg, mar_next;
    logic [7:0] acc_reg, acc_next;
    logic [1:0] flags_reg, flags_next;
    logic [3:0] dec_op;

    assign dec_op = mem_data_i[7:4];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= FETCH;
            pc_reg    <= RST_PC;
            ir_reg    <= 4'h0;
            mar_reg   <= 8'h00;
            acc_reg   <= 8'h00;
            flags_reg <= 2'b00;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            mar_reg   <= mar_next;
            acc_reg   <= acc_next;
            flags_reg <= flags_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        mar_next   = mar_reg;
        acc_next   = acc_reg;
        flags_next = flags_reg;
        mem_addr_o = pc_reg;
        mem_rd_o   = 1'b0;
        mem_wr_o   = 1'b0;
        alu_op_o   = ALU_ADD;

        case (state_reg)
            FETCH: begin
                if (run_i) begin
                    mem_rd_o   = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                ir_next = dec_op;
                pc_next = pc_reg + 8'h01;
                if (dec_op == OP_NOP) begin
                    state_next = FETCH;
                end else if (dec_op == OP_HLT || dec_op[3]) begin
                    state_next = HALT;
                end else begin
                    state_next = FETCHA;
                end
            end
            FETCHA: begin
                mem_rd_o   = 1'b1;
                state_next = LOADA;
            end
            LOADA: begin
                mar_next = mem_data_i;
                pc_next  = pc_reg + 8'h01;
                case (ir_reg)
                    OP_JMP, OP_JZ, OP_JC: begin
                        // Conditions use the latched flags, never the live ALU flags.
                        if ((ir_reg == OP_JMP) ||
                            (ir_reg == OP_JZ && flags_reg[0]) ||
                            (ir_reg == OP_JC && flags_reg[1])) begin
                            pc_next = mem_data_i;
                        end
                        state_next = FETCH;
                    end
                    OP_STA:  state_next = STORE;
                    default: state_next = READ;
                endcase
            end
            STORE: begin
                mem_addr_o = mar_reg;
                mem_wr_o   = 1'b1;
                state_next = FETCH;
            end
            READ: begin
                mem_addr_o = mar_reg;
                mem_rd_o   = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                case (ir_reg)
                    OP_ADD:  alu_op_o = ALU_ADD;
                    OP_SUB:  alu_op_o = ALU_SUB;
                    default: alu_op_o = ALU_LDA;
                endcase
                acc_next      = alu_r_i;
                flags_next[0] = alu_flags_i[0];
                // A load keeps the carry from the last arithmetic operation.
                if (ir_reg != OP_LDA) begin
                    flags_next[1] = alu_flags_i[1];
                end
                state_next = FETCH;
            end
            default: state_next = HALT;
        endcase

        if (!rst_ni) begin
            mem_rd_o = 1'b0;
            mem_wr_o = 1'b0;
            alu_op_o = ALU_ADD;
        end
    end

    assign mem_data_o = acc_reg;
    assign alu_x_o    = acc_reg;
    assign alu_y_o    = mem_data_i;
    assign pc_o       = pc_reg;
    assign acc_o      = acc_reg;
    assign flags_o    = flags_reg;
    assign halted_o   = (state_reg == HALT);
    assign illegal_o  = (state_reg == HALT) && ir_reg[3] && (ir_reg != OP_HLT);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: behavioural ALU and sync memory around the DUT, checked
// instruction by instruction against an ISA-level reference model.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       run_i;
    logic [7:0] mem_addr_o;
    logic       mem_rd_o;
    logic       mem_wr_o;
    logic [7:0] mem_data_i;
    logic [7:0] mem_data_o;
    logic [7:0] alu_x_o;
    logic [7:0] alu_y_o;
    logic [2:0] alu_op_o;
    logic [7:0] alu_r;
    logic       alu_c;
    logic [1:0] alu_flags;
    logic [7:0] pc_o;
    logic [7:0] acc_o;
    logic [1:0] flags_o;
    logic       halted_o;
    logic       illegal_o;

    always #5 clk = ~clk;

    control_unit #(.RST_PC(8'h00)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .run_i      (run_i),
        .mem_addr_o (mem_addr_o),
        .mem_rd_o   (mem_rd_o),
        .mem_wr_o   (mem_wr_o),
        .mem_data_i (mem_data_i),
        .mem_data_o (mem_data_o),
        .alu_x_o    (alu_x_o),
        .alu_y_o    (alu_y_o),
        .alu_op_o   (alu_op_o),
        .alu_r_i    (alu_r),
        .alu_flags_i(alu_flags),
        .pc_o       (pc_o),
        .acc_o      (acc_o),
        .flags_o    (flags_o),
        .halted_o   (halted_o),
        .illegal_o  (illegal_o)
    );

    // Environment ALU: flags are Z in bit 0, carry/borrow in bit 1.
    always_comb begin
        alu_r = 8'h00;
        alu_c = 1'b0;
        case (alu_op_o)
            3'b000: {alu_c, alu_r} = {1'b0, alu_x_o} + {1'b0, alu_y_o};
            3'b001: begin
                alu_r = alu_x_o - alu_y_o;
                alu_c = (alu_x_o < alu_y_o);
            end
            3'b010: alu_r = alu_y_o;
            default: ;
        endcase
    end
    assign alu_flags = {alu_c, (alu_r == 8'h00)};

    // Sync memory with a side port used only to load programs while the DUT is in reset.
    logic [7:0] mem [256];
    logic       load_en;
    logic [7:0] load_addr;
    logic [7:0] load_data;
    int         rd_cnt = 0;
    int         wr_cnt = 0;

    always @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end else begin
            if (mem_rd_o) mem_data_i <= mem[mem_addr_o];
            if (mem_wr_o) mem[mem_addr_o] <= mem_data_o;
        end
        if (mem_rd_o) rd_cnt <= rd_cnt + 1;
        if (mem_wr_o) wr_cnt <= wr_cnt + 1;
    end

    // Reference model state (ISA level).
    logic [7:0] mdl_mem [256];
    logic [7:0] mdl_pc;
    logic [7:0] mdl_acc;
    logic       mdl_z;
    logic       mdl_c;
    logic       mdl_halt;
    logic       mdl_ill;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Executes one instruction; returns its cycle count and number of memory writes.
    task automatic model_step(output int cyc, output int nwr);
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] m;
        logic [8:0] s;
        nwr = 0;
        op = mdl_mem[mdl_pc][7:4];
        mdl_pc = mdl_pc + 8'h01;
        if (op == 4'h0) begin
            cyc = 2;
        end else if (op >= 4'h8) begin
            cyc = 2;
            mdl_halt = 1'b1;
            mdl_ill = (op != 4'hF);
        end else begin
            a = mdl_mem[mdl_pc];
            mdl_pc = mdl_pc + 8'h01;
            m = mdl_mem[a];
            case (op)
                4'h5, 4'h6, 4'h7: begin
                    cyc = 4;
                    if (op == 4'h5 || (op == 4'h6 && mdl_z) || (op == 4'h7 && mdl_c))
                        mdl_pc = a;
                end
                4'h2: begin
                    cyc = 5;
                    mdl_mem[a] = mdl_acc;
                    nwr = 1;
                end
                default: begin
                    cyc = 6;
                    if (op == 4'h1) begin
                        mdl_acc = m;
                    end else if (op == 4'h3) begin
                        s = {1'b0, mdl_acc} + {1'b0, m};
                        mdl_acc = s[7:0];
                        mdl_c = s[8];
                    end else begin
                        mdl_c = (mdl_acc < m);
                        mdl_acc = mdl_acc - m;
                    end
                    mdl_z = (mdl_acc == 8'h00);
                end
            endcase
        end
    endtask

    task automatic load_and_reset();
        rst_ni = 1'b0;
        run_i  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            load_en   = 1'b1;
            load_addr = 8'(i);
            load_data = mdl_mem[i];
            @(posedge clk); #1;
        end
        load_en = 1'b0;
        check("rst_rd", mem_rd_o, 0);
        check("rst_wr", mem_wr_o, 0);
        check("rst_aluop", alu_op_o, 0);
        check("rst_pc", pc_o, 8'h00);
        check("rst_acc", acc_o, 8'h00);
        check("rst_flags", flags_o, 2'b00);
        check("rst_halted", halted_o, 0);
        check("rst_illegal", illegal_o, 0);
        mdl_pc = 8'h00; mdl_acc = 8'h00; mdl_z = 1'b0; mdl_c = 1'b0;
        mdl_halt = 1'b0; mdl_ill = 1'b0;
        rst_ni = 1'b1;
    endtask

    task automatic run_instr();
        int cyc, nwr, k, r0, w0;
        logic [7:0] pc0;
        if ($urandom_range(0, 3) == 0) begin
            run_i = 1'b0;
            k = $urandom_range(1, 3);
            r0 = rd_cnt;
            w0 = wr_cnt;
            repeat (k) @(posedge clk);
            #1;
            check("idle_pc", pc_o, mdl_pc);
            check("idle_strobes", (rd_cnt - r0) + (wr_cnt - w0), 0);
        end
        pc0 = mdl_pc;
        w0 = wr_cnt;
        model_step(cyc, nwr);
        run_i = 1'b1;
        @(posedge clk); #1;
        // run_i is ignored once the instruction has started.
        repeat (cyc - 1) begin
            run_i = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        run_i = 1'b1;
        $display("instr @%02h op=%02h cyc=%0d pc=%02h acc=%02h flags=%b",
                 pc0, mdl_mem[pc0], cyc, pc_o, acc_o, flags_o);
        check("pc", pc_o, mdl_pc);
        check("acc", acc_o, mdl_acc);
        check("flags", flags_o, {mdl_c, mdl_z});
        check("halted", halted_o, mdl_halt);
        check("illegal", illegal_o, mdl_ill);
        check("writes", wr_cnt - w0, nwr);
    endtask

    task automatic run_program(input int max_instr);
        int r0, w0;
        for (int n = 0; n < max_instr && !mdl_halt; n++) run_instr();
        if (mdl_halt) begin
            r0 = rd_cnt;
            w0 = wr_cnt;
            repeat (5) @(posedge clk);
            #1;
            check("halt_hold", halted_o, 1);
            check("halt_pc", pc_o, mdl_pc);
            check("halt_strobes", (rd_cnt - r0) + (wr_cnt - w0), 0);
        end
        for (int i = 0; i < 256; i++) check("mem", mem[i], mdl_mem[i]);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
    endtask

    function automatic logic [7:0] rand_opbyte();
        int r;
        logic [3:0] op;
        r = $urandom_range(0, 99);
        if (r < 2) op = 4'hF;
        else if (r < 4) op = 4'(8 + $urandom_range(0, 6));
        else op = 4'($urandom_range(0, 7));
        return {op, 4'($urandom_range(0, 15))};
    endfunction

    initial begin
        int w0;
        rst_ni = 1'b0;
        run_i = 1'b0;
        load_en = 1'b0;
        load_addr = 8'h00;
        load_data = 8'h00;

        // Sample program: LDA 20; ADD 21; STA 22; HLT.
        clear_prog();
        mdl_mem[0] = 8'h10; mdl_mem[1] = 8'h20; mdl_mem[2] = 8'h30; mdl_mem[3] = 8'h21;
        mdl_mem[4] = 8'h20; mdl_mem[5] = 8'h22; mdl_mem[6] = 8'hF0;
        mdl_mem[8'h20] = 8'h05; mdl_mem[8'h21] = 8'hFB; mdl_mem[8'h22] = 8'hAA;
        load_and_reset();
        w0 = wr_cnt;
        run_i = 1'b1;
        repeat (18) @(posedge clk);
        #1;
        check("t1_halt_at18", halted_o, 0);
        @(posedge clk); #1;
        check("t1_halt_at19", halted_o, 1);
        check("t1_acc", acc_o, 8'h00);
        check("t1_flags", flags_o, 2'b11);
        check("t1_pc", pc_o, 8'h07);
        check("t1_mem22", mem[8'h22], 8'h00);
        check("t1_writes", wr_cnt - w0, 1);
        check("t1_illegal", illegal_o, 0);

        // SUB borrow, then LDA of zero keeps carry.
        clear_prog();
        mdl_mem[0] = 8'h10; mdl_mem[1] = 8'h30; mdl_mem[2] = 8'h40; mdl_mem[3] = 8'h31;
        mdl_mem[4] = 8'h10; mdl_mem[5] = 8'h32; mdl_mem[6] = 8'hF0;
        mdl_mem[8'h30] = 8'h03; mdl_mem[8'h31] = 8'h05; mdl_mem[8'h32] = 8'h00;
        load_and_reset();
        run_program(10);
        check("t2_acc", acc_o, 8'h00);
        check("t2_flags", flags_o, 2'b11);

        // Conditional jumps, taken and not taken.
        clear_prog();
        mdl_mem[8'h00] = 8'h10; mdl_mem[8'h01] = 8'h50; mdl_mem[8'h02] = 8'h60; mdl_mem[8'h03] = 8'h40;
        mdl_mem[8'h40] = 8'h10; mdl_mem[8'h41] = 8'h51; mdl_mem[8'h42] = 8'h60; mdl_mem[8'h43] = 8'h00;
        mdl_mem[8'h44] = 8'h70; mdl_mem[8'h45] = 8'h00;
        mdl_mem[8'h46] = 8'h30; mdl_mem[8'h47] = 8'h52; mdl_mem[8'h48] = 8'h70; mdl_mem[8'h49] = 8'h80;
        mdl_mem[8'h80] = 8'hF0;
        mdl_mem[8'h50] = 8'h00; mdl_mem[8'h51] = 8'h01; mdl_mem[8'h52] = 8'hFF;
        load_and_reset();
        run_program(20);
        check("t3_pc", pc_o, 8'h81);

        // Illegal opcode after NOPs.
        clear_prog();
        mdl_mem[5] = 8'h93;
        load_and_reset();
        run_program(20);
        check("t4_pc", pc_o, 8'h06);
        check("t4_illegal", illegal_o, 1);

        // Reset during the operand fetch of STA.
        clear_prog();
        mdl_mem[0] = 8'h10; mdl_mem[1] = 8'h40; mdl_mem[2] = 8'h20; mdl_mem[3] = 8'h30;
        mdl_mem[8'h40] = 8'h77; mdl_mem[8'h30] = 8'hAA;
        load_and_reset();
        run_instr();
        run_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t5_rd_before", mem_rd_o, 1);
        w0 = wr_cnt;
        rst_ni = 1'b0;
        #1;
        check("t5_rd_gated", mem_rd_o, 0);
        @(posedge clk); #1;
        check("t5_pc", pc_o, 8'h00);
        check("t5_acc", acc_o, 8'h00);
        check("t5_flags", flags_o, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        check("t5_writes", wr_cnt - w0, 0);
        check("t5_mem30", mem[8'h30], 8'hAA);

        // PC wrap: NOP at FF, then JMP at FF with its operand at 00.
        clear_prog();
        mdl_mem[8'h00] = 8'h50; mdl_mem[8'h01] = 8'hFF; mdl_mem[8'hFF] = 8'h00;
        load_and_reset();
        run_instr();
        run_instr();
        check("t6_nop_wrap", pc_o, 8'h00);
        clear_prog();
        mdl_mem[8'h00] = 8'h10; mdl_mem[8'h01] = 8'h05; mdl_mem[8'h02] = 8'h50; mdl_mem[8'h03] = 8'hFF;
        mdl_mem[8'hFF] = 8'h50; mdl_mem[8'h10] = 8'hF0;
        load_and_reset();
        run_program(10);
        check("t6_jmp_wrap", pc_o, 8'h11);

        // Random programs: even bytes biased towards opcodes, odd bytes uniform.
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 256; i++)
                mdl_mem[i] = (i % 2 == 0) ? rand_opbyte() : 8'($urandom_range(0, 255));
            load_and_reset();
            run_program(60);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
